// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, Nk/Nr lookup, xtime, rcon seed, word type.
// Pure declarations: no latency or backpressure of its own.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] KL_128  = 2'd0;
  localparam logic [1:0] KL_192  = 2'd1;
  localparam logic [1:0] KL_256  = 2'd2;
  localparam logic [1:0] KL_RSVD = 2'd3;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} ks_state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
// Purely combinational, zero latency, no handshake.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain to x^254, which is the multiplicative inverse (0 maps to 0).
  assign x2   = gmul(din, din);
  assign x3   = gmul(x2, din);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one word per cycle; done at 2+4*Nr+4-Nk cycles after start.
// start is ignored while busy; optional AES_KS_ZEROIZE_EN adds a zeroize clear input.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int RK_MAX  = 15,
  parameter bit REG_OUT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         key_valid,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
`ifdef AES_KS_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  localparam int NW = 4 * RK_MAX;

  ks_state_t  state;
  word_t      w   [NW];
  word_t      win [8];
  logic [5:0] i;
  logic [2:0] pos;
  logic [7:0] rcon;
  logic [3:0] nk_l;
  logic [3:0] nr_l;

  word_t prev, rot, sb_in, sb_out, temp, nw;
  logic  last;

  function automatic word_t key_word(input logic [255:0] k, input int j);
    return k[255 - 32*j -: 32];
  endfunction

  // win[0] is always w[i-Nk] and win[Nk-1] is w[i-1]; slots above Nk-1 are unused.
  assign prev  = win[3'(nk_l - 4'd1)];
  assign rot   = {prev[23:0], prev[31:24]};
  assign sb_in = (pos == 3'd0) ? rot : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sb_in[8*b +: 8]),
      .dout (sb_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = prev;
    if (pos == 3'd0)
      temp = sb_out ^ {rcon, 24'h000000};
    else if (nk_l == 4'd8 && pos == 3'd4)
      temp = sb_out;
  end

  assign nw   = win[0] ^ temp;
  assign last = (i == {nr_l, 2'b11});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
      nr        <= 4'd0;
      i         <= 6'd0;
      pos       <= 3'd0;
      rcon      <= 8'h00;
      nk_l      <= 4'd4;
      nr_l      <= 4'd10;
    end
`ifdef AES_KS_ZEROIZE_EN
    else if (zeroize) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (key_len == KL_RSVD) begin
              err <= 1'b1;
            end else begin
              nk_l      <= nk_of(key_len);
              nr_l      <= nr_of(key_len);
              key_valid <= 1'b0;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          i     <= 6'(nk_l);
          pos   <= 3'd0;
          rcon  <= RCON_INIT;
          state <= S_EXPAND;
        end
        S_EXPAND: begin
          i   <= i + 6'd1;
          pos <= (pos == 3'(nk_l - 4'd1)) ? 3'd0 : pos + 3'd1;
          if (pos == 3'd0) rcon <= xtime(rcon);
          if (last) begin
            done      <= 1'b1;
            key_valid <= 1'b1;
            nr        <= nr_l;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word storage is deliberately left out of rst so a reset never costs a re-expansion of state it does not own.
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef AES_KS_ZEROIZE_EN
      if (zeroize) begin
        for (int j = 0; j < NW; j++) w[j] <= '0;
        for (int j = 0; j < 8; j++) win[j] <= '0;
      end else
`endif
      if (state == S_LOAD) begin
        for (int j = 0; j < 8; j++) begin
          win[j] <= key_word(cipher_key, j);
          if (j < int'(nk_l)) w[j] <= key_word(cipher_key, j);
        end
      end else if (state == S_EXPAND) begin
        if (int'(i) < NW) w[i] <= nw;
        for (int j = 0; j < 7; j++) win[j] <= win[j+1];
        win[3'(nk_l - 4'd1)] <= nw;
      end
    end
  end

  logic [5:0]   base;
  logic         rd_ok;
  logic [127:0] rk_comb;

  // nr is zero until a schedule completes, which also blanks reads after reset.
  assign base    = {rk_idx, 2'b00};
  assign rd_ok   = (nr != 4'd0) && (rk_idx <= nr) && (int'(base) + 3 < NW);
  assign rk_comb = rd_ok ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;

  if (REG_OUT) begin : g_reg_out
    logic [127:0] rk_q;
    always_ff @(posedge clk) begin
      if (rst)
        rk_q <= '0;
`ifdef AES_KS_ZEROIZE_EN
      else if (zeroize)
        rk_q <= '0;
`endif
      else
        rk_q <= rk_comb;
    end
    assign rk_out = rk_q;
  end else begin : g_comb_out
    assign rk_out = rk_comb;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised, iterative AES key schedule supporting AES-128/192/256 selected at run time. It expands a cipher key into the full round-key set, one 32-bit word per cycle, into internal storage. The cipher datapath then reads any round key by index through a registered read port. It replaces the fixed 128-bit, one-round-per-enable key expander and sits beside the round engine in the AES core.

## Interface
- `RK_MAX`, default 15: number of 128-bit round-key slots; must be ≥ Nr+1 of the largest mode used.
- `REG_OUT`, default 1: 1 = `rk_out` registered (1-cycle read latency); 0 = combinational read.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous and active-high.
- `start` in 1: request expansion; sampled only in IDLE.
- `key_len` in 2: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- `cipher_key` in 256: MSB-aligned key. 128-bit mode uses [255:128]; 192-bit mode uses [255:64].
- `busy` in/out: out 1; expansion in progress.
- `done` out 1: one-cycle pulse when the schedule is complete.
- `err` out 1: one-cycle pulse when `start` is given with `key_len` = 3.
- `key_valid` out 1: a complete schedule is stored.
- `nr` out 4: round count of the stored schedule (10/12/14); 0 after reset.
- `rk_idx` in 4: round-key index to read.
- `rk_out` out 128: round key `rk_idx`, as {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
- `zeroize` in 1: present only with `AES_KS_ZEROIZE_EN`.

## Operation
- States: IDLE → LOAD → EXPAND → IDLE.
- **IDLE:**
  - `start`=1 with a valid `key_len`: latch Nk (4/6/8) and Nr (10/12/14), clear `key_valid`, go to LOAD.
  - `start`=1 with `key_len`=3: pulse `err`, stay in IDLE, leave stored keys and `key_valid` unchanged.
- **LOAD** (1 cycle): write w[0..Nk-1] from `cipher_key`, fill the Nk-word sliding window, set i = Nk and rcon = 0x01.
- **EXPAND:** one word per cycle for i = Nk .. 4·Nr+3.
  - temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- After the last word: pulse `done`, set `key_valid`, update `nr`, go to IDLE.
- Counters and widths: i is 6 bits; the mod-Nk position counter is 3 bits and wraps at Nk; rcon is an 8-bit xtime register (0x80 → 0x1b → 0x36).
- `start` while busy: ignored.
- Reads:
  - Reads are allowed at any time.
  - While busy, a read returns partially rewritten content, and `key_valid`=0 flags it.
  - `rk_idx` > `nr`, or any read before the first completion: `rk_out` = 0.
- Reset values: state IDLE; `busy`, `done`, `err`, `key_valid` = 0; `nr` = 0; `rk_out` = 0. Word storage is not cleared by `rst`.
- `rst` mid-expansion: abort immediately to IDLE with `key_valid`=0; any later read returns 0 until the next completion.

## Timing
- Count `start` high at cycle 0 in IDLE.
- `busy`: high from cycle 1 (LOAD) through the last EXPAND cycle.
- `done`: high and `busy` low at cycle 2 + 4·Nr + 4 − Nk.
  - AES-128: cycle 42.
  - AES-192: cycle 48.
  - AES-256: cycle 54.
- `key_valid`: rises together with `done`.
- A new `start` is accepted in the `done` cycle.
- `rk_out`, REG_OUT=1: reflects the `rk_idx` sampled at the previous edge.
- `rk_out`, REG_OUT=0: reflects the current `rk_idx` in the same cycle.
- `err`: pulses in cycle 1.

## Configuration
- Macro `AES_KS_ZEROIZE_EN`.
- Defined:
  - `zeroize` port exists.
  - `zeroize`=1 clears all word storage, the window, `rk_out` and `key_valid` in one cycle, and forces IDLE.
  - `zeroize` has priority over `start` and over expansion, but not over `rst`.
- Undefined: no port, no clear logic; storage persists until overwritten.

## Structure
- Shared package `aes_pkg`: key-length encoding constants, Nk/Nr lookup functions, `xtime` function, rcon initial value, 32-bit word typedef.
- Reuse the existing `aes_sbox` sub-module, four instances on the SubWord path.
- No other sub-modules.
- Storage: 4·RK_MAX × 32-bit register array.

## Test plan
- **AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c → `done` at cycle 42; rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rk 0 = the key; `nr` = 10.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → `done` at cycle 48; rk 12 = e98ba06f448c773c8ecc720401002202.
- **AES-256:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → `done` at cycle 54; rk 14 = fe4890d1e6188d0b046df344706c631e.
- **Control corner cases:**
  - `key_len`=3 → `err` at cycle 1, `busy` stays 0.
  - `start` pulsed at cycle 10 of an expansion → ignored.
  - `rk_idx`=11 after AES-128 → `rk_out` = 0.
- **Mid-run reset:** `rst` at cycle 20 of AES-256 → IDLE, `key_valid`=0, `rk_out`=0. A following AES-128 run then completes at cycle 42 with the correct rk 10.
- **Zeroize (`AES_KS_ZEROIZE_EN`):** `zeroize` after an AES-128 completion → next-cycle `key_valid`=0 and every `rk_idx` reads 0.
